// File: rtl/ma_filter_param_if.sv
// Valid/ready sample stream bundle shared by the filter input and output.
// Ports: valid/data flow master -> slave, ready flows slave -> master.
// A beat transfers on a clock edge where valid && ready.
interface ma_filter_param_if #(
  parameter int DATA_W = 16
);
  logic                     valid;
  logic                     ready;
  logic signed [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ma_filter_param.sv
// Recursive moving-average filter over a 2**LOG2_N window with full-precision running sum.
// Latency: 1 cycle from input accept to out_if.valid carrying the new average.
// Backpressure: in_if.ready drops when the output register is full and not draining, or on flush.
// Ports: clk, reset (sync, active-high), flush (sync history clear), in_if (slave stream x[n]),
//        out_if (master stream y[n]), warm (window filled since last reset/flush).
module ma_filter_param #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 3,
  parameter int ROUND  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  ma_filter_param_if.slave      in_if,
  ma_filter_param_if.master     out_if,
  output logic                  warm
);

  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int EXT_W = ACC_W + 1;
  // Half an LSB of the output, added before the shift when rounding is enabled.
  localparam logic signed [EXT_W-1:0] RND_ADD = EXT_W'((ROUND != 0) ? (1 << (LOG2_N - 1)) : 0);

  logic signed [DATA_W-1:0] hist_q [N];

  logic [LOG2_N-1:0]        wptr_q, wptr_d;
  logic [LOG2_N:0]          fill_q, fill_d;     // saturates at N, so the MSB alone means "full"
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     out_vld_q, out_vld_d;
  logic signed [DATA_W-1:0] out_dat_q, out_dat_d;

  logic                     accept;
  logic                     full;
  logic signed [DATA_W-1:0] oldest;
  logic signed [EXT_W-1:0]  sum_ext;
  logic signed [EXT_W-1:0]  y_ext;

  assign full         = fill_q[LOG2_N];
  assign in_if.ready  = !flush && (!out_vld_q || out_if.ready);
  assign accept       = in_if.valid && in_if.ready;
  assign out_if.valid = out_vld_q;
  assign out_if.data  = out_dat_q;
  assign warm         = full;

  // Until the window has been filled once, the slot under the pointer holds
  // stale data from before reset/flush, so the departing sample is taken as 0.
  assign oldest  = full ? hist_q[wptr_q] : '0;
  assign sum_ext = EXT_W'(acc_q) + EXT_W'(in_if.data) - EXT_W'(oldest);
  assign y_ext   = (sum_ext + RND_ADD) >>> LOG2_N;

  always_comb begin
    acc_d     = acc_q;
    wptr_d    = wptr_q;
    fill_d    = fill_q;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    if (accept) begin
      acc_d     = ACC_W'(sum_ext);
      wptr_d    = wptr_q + 1'b1;
      out_vld_d = 1'b1;
      out_dat_d = DATA_W'(y_ext);
      if (!full) begin
        fill_d = fill_q + 1'b1;
      end
    end else if (out_if.ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      acc_q     <= '0;
      wptr_q    <= '0;
      fill_q    <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      acc_q     <= acc_d;
      wptr_q    <= wptr_d;
      fill_q    <= fill_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end

  // History is deliberately not cleared; the fill count masks stale entries.
  always_ff @(posedge clk) begin
    if (accept) begin
      hist_q[wptr_q] <= in_if.data;
    end
  end

endmodule

// File: tb/tb_ma_filter_param.sv
module tb_ma_filter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               flush;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_ready;
  logic               warm0, warm1, warm2, warm3;

  ma_filter_param_if #(.DATA_W(16)) i0(), o0(), i1(), o1(), i2(), o2(), i3(), o3();

  assign i0.valid = in_valid;  assign i0.data = in_data;  assign o0.ready = out_ready;
  assign i1.valid = in_valid;  assign i1.data = in_data;  assign o1.ready = out_ready;
  assign i2.valid = in_valid;  assign i2.data = in_data;  assign o2.ready = out_ready;
  assign i3.valid = in_valid;  assign i3.data = in_data;  assign o3.ready = out_ready;

  ma_filter_param #(.DATA_W(16), .LOG2_N(3), .ROUND(0)) u0 (
    .clk(clk), .reset(reset), .flush(flush), .in_if(i0), .out_if(o0), .warm(warm0));
  ma_filter_param #(.DATA_W(16), .LOG2_N(3), .ROUND(1)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .in_if(i1), .out_if(o1), .warm(warm1));
  ma_filter_param #(.DATA_W(16), .LOG2_N(1), .ROUND(0)) u2 (
    .clk(clk), .reset(reset), .flush(flush), .in_if(i2), .out_if(o2), .warm(warm2));
  ma_filter_param #(.DATA_W(16), .LOG2_N(6), .ROUND(0)) u3 (
    .clk(clk), .reset(reset), .flush(flush), .in_if(i3), .out_if(o3), .warm(warm3));

  int errors = 0;
  int checks = 0;

  // Every sample accepted since the last reset/flush, oldest first.
  int hist[$];
  logic signed [15:0] exp0[$], exp1[$], exp2[$], exp3[$];

  // Results of the most recent tick.
  bit                 took;
  bit                 popped;
  logic signed [15:0] d0, d1, d2, d3;
  logic signed [15:0] e0, e1, e2, e3;

  // Zero-padded window sum of the last 2**l2 accepted samples, divided by 2**l2.
  function automatic int exp_y(int l2, bit rnd);
    int n = 1 << l2;
    int s = 0;
    for (int i = 0; i < n; i++) begin
      if (hist.size() > i) s += hist[hist.size() - 1 - i];
    end
    if (rnd) s += 1 << (l2 - 1);
    return s >>> l2;
  endfunction

  // Inputs are already set; sample pre-edge handshake, update scoreboard, advance one clock.
  task automatic tick();
    #1;
    took   = in_valid && i0.ready;
    popped = 1'b0;
    d0 = o0.data; d1 = o1.data; d2 = o2.data; d3 = o3.data;
    if (reset || flush) begin
      hist.delete();
      exp0.delete(); exp1.delete(); exp2.delete(); exp3.delete();
    end else begin
      if (o0.valid && out_ready) begin
        popped = 1'b1;
        e0 = (exp0.size() > 0) ? exp0.pop_front() : 16'bx;
        e1 = (exp1.size() > 0) ? exp1.pop_front() : 16'bx;
        e2 = (exp2.size() > 0) ? exp2.pop_front() : 16'bx;
        e3 = (exp3.size() > 0) ? exp3.pop_front() : 16'bx;
      end
      if (took) begin
        hist.push_back(int'(in_data));
        exp0.push_back(16'(exp_y(3, 1'b0)));
        exp1.push_back(16'(exp_y(3, 1'b1)));
        exp2.push_back(16'(exp_y(1, 1'b0)));
        exp3.push_back(16'(exp_y(6, 1'b0)));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; in_valid = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    checks++; if (o0.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", o0.valid); end
    checks++; if (o0.data !== 16'sd0) begin errors++; $display("FAIL reset_out_data got %0d exp 0", o0.data); end
    checks++; if (warm0 !== 1'b0) begin errors++; $display("FAIL reset_warm got %0b exp 0", warm0); end
    checks++; if (i0.ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", i0.ready); end
  endtask

  task automatic test_step();
    logic signed [15:0] want;
    out_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      in_valid = 1'b1; in_data = 16'sd800;
      tick();
      want = 16'((i < 8 ? i : 8) * 100);
      checks++; if (o0.data !== want) begin errors++; $display("FAIL step_y[%0d] got %0d exp %0d", i, o0.data, want); end
      checks++; if (warm0 !== (i >= 8)) begin errors++; $display("FAIL step_warm[%0d] got %0b exp %0b", i, warm0, (i >= 8)); end
      if (popped) begin
        checks++; if (d0 !== e0) begin errors++; $display("FAIL step_sb got %0d exp %0d", d0, e0); end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (o0.valid !== 1'b0) begin errors++; $display("FAIL step_drain_valid got %0b exp 0", o0.valid); end
  endtask

  task automatic test_impulse();
    logic signed [15:0] want;
    do_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = (i == 0) ? 16'sd80 : 16'sd0;
      tick();
      want = (i < 8) ? 16'sd10 : 16'sd0;
      checks++; if (o0.data !== want) begin errors++; $display("FAIL impulse_y[%0d] got %0d exp %0d", i, o0.data, want); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_extremes();
    do_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_data = (i < 20) ? 16'sh7fff : 16'sh8000;
      tick();
      if (popped) begin
        checks++; if (d0 !== e0 || d1 !== e1 || d2 !== e2 || d3 !== e3)
          begin errors++; $display("FAIL extreme_sb got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", d0, d1, d2, d3, e0, e1, e2, e3); end
      end
      if (i == 19) begin
        checks++; if (o0.data !== 16'sh7fff) begin errors++; $display("FAIL extreme_max got %0d exp 32767", o0.data); end
      end
    end
    checks++; if (o0.data !== 16'sh8000) begin errors++; $display("FAIL extreme_min got %0d exp -32768", o0.data); end
    do_flush();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = -16'sd1;
      tick();
      if (i == 0) begin
        checks++; if (o0.data !== -16'sd1) begin errors++; $display("FAIL neg1_floor got %0d exp -1", o0.data); end
        checks++; if (o1.data !== 16'sd0) begin errors++; $display("FAIL neg1_round got %0d exp 0", o1.data); end
      end
      if (popped) begin
        checks++; if (d0 !== e0 || d1 !== e1) begin errors++; $display("FAIL neg1_sb got %0d/%0d exp %0d/%0d", d0, d1, e0, e1); end
      end
    end
    checks++; if (o0.data !== -16'sd1) begin errors++; $display("FAIL neg1_steady got %0d exp -1", o0.data); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int pops = 0;
    do_flush();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 16'(100 * i);
      tick();
      if (popped) begin
        pops++;
        checks++; if (d0 !== e0) begin errors++; $display("FAIL bp_sb got %0d exp %0d", d0, e0); end
      end
    end
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'sd400;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (i0.ready !== 1'b0 || o0.valid !== 1'b1 || o0.data !== 16'sd75)
        begin errors++; $display("FAIL bp_stall[%0d] got rdy=%0b vld=%0b y=%0d exp rdy=0 vld=1 y=75", i, i0.ready, o0.valid, o0.data); end
    end
    out_ready = 1'b1;
    for (int i = 4; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(100 * i);
      tick();
      if (popped) begin
        pops++;
        checks++; if (d0 !== e0) begin errors++; $display("FAIL bp_sb got %0d exp %0d", d0, e0); end
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && exp0.size() > 0; i++) begin
      tick();
      if (popped) begin
        pops++;
        checks++; if (d0 !== e0) begin errors++; $display("FAIL bp_sb got %0d exp %0d", d0, e0); end
      end
    end
    checks++; if (pops !== 8) begin errors++; $display("FAIL bp_count got %0d exp 8", pops); end
  endtask

  task automatic test_restart(bit use_reset);
    do_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 16'sd800;
      tick();
    end
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    in_valid = 1'b1; in_data = 16'sd800;
    tick();
    reset = 1'b0; flush = 1'b0;
    checks++; if (o0.valid !== 1'b0 || warm0 !== 1'b0)
      begin errors++; $display("FAIL restart%0b_clear got vld=%0b warm=%0b exp 0 0", use_reset, o0.valid, warm0); end
    in_valid = 1'b1; in_data = 16'sd8;
    tick();
    checks++; if (o0.data !== 16'sd1 || warm0 !== 1'b0)
      begin errors++; $display("FAIL restart%0b_first got y=%0d warm=%0b exp y=1 warm=0", use_reset, o0.data, warm0); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int n = 0;
    int cyc = 0;
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0;
    while (n < 2000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 999) == 0);
      tick();
      cyc++;
      if (took) n++;
      if (popped) begin
        checks++; if (d0 !== e0 || d1 !== e1 || d2 !== e2 || d3 !== e3)
          begin errors++; $display("FAIL rand_sb got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", d0, d1, d2, d3, e0, e1, e2, e3); end
      end
    end
    flush = 1'b0;
    checks++; if (n < 2000) begin errors++; $display("FAIL rand_budget got %0d accepts exp 2000", n); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && exp0.size() > 0; i++) begin
      tick();
      if (popped) begin
        checks++; if (d0 !== e0 || d1 !== e1 || d2 !== e2 || d3 !== e3)
          begin errors++; $display("FAIL rand_sb got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", d0, d1, d2, d3, e0, e1, e2, e3); end
      end
    end
    checks++; if (exp0.size() !== 0 || o0.valid !== 1'b0)
      begin errors++; $display("FAIL rand_leftover got %0d pending vld=%0b exp 0 pending vld=0", exp0.size(), o0.valid); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_step();
    test_impulse();
    test_extremes();
    test_backpressure();
    test_restart(1'b0);
    test_restart(1'b1);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
